// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared flag indices, condition-code constants and PSR type
package proc_pkg;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Bit order {C,L,F,Z,N}
  typedef logic [4:0] psr_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - writeback stage bus; WB_FWD_EN adds the forwarding outputs
interface wb_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
) ();
  import proc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic [4:0]    in_cond;
  logic          in_flags_we;
  logic [RW-1:0] in_rd;
  logic          in_rd_we;
  logic          in_branch;
  logic [3:0]    in_bcond;
  logic [DW-1:0] in_target;
  logic          stall;
  logic          flush;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  psr_t          psr;
  logic          br_taken;
  logic [DW-1:0] br_target;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  modport master (
    output in_valid, in_result, in_cond, in_flags_we, in_rd, in_rd_we,
           in_branch, in_bcond, in_target, stall, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, psr, br_taken, br_target
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport slave (
    input  in_valid, in_result, in_cond, in_flags_we, in_rd, in_rd_we,
           in_branch, in_bcond, in_target, stall, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, psr, br_taken, br_target
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );

endinterface

// File: rtl/wb_stage_cond_eval.sv
// rtl/wb_stage_cond_eval.sv - combinational branch condition evaluator, shared with fetch
module cond_eval
  import proc_pkg::*;
(
  input  logic [3:0] i_bcond,
  input  psr_t       i_psr,
  output logic       o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;

  assign w_c = i_psr[FLAG_C];
  assign w_l = i_psr[FLAG_L];
  assign w_f = i_psr[FLAG_F];
  assign w_z = i_psr[FLAG_Z];
  assign w_n = i_psr[FLAG_N];

  always_comb begin
    o_taken = 1'b0;
    case (i_bcond)
      CC_EQ:   o_taken = w_z;
      CC_NE:   o_taken = !w_z;
      CC_CS:   o_taken = w_c;
      CC_CC:   o_taken = !w_c;
      CC_HI:   o_taken = w_l;
      CC_LS:   o_taken = !w_l;
      CC_GT:   o_taken = w_n;
      CC_LE:   o_taken = !w_n;
      CC_FS:   o_taken = w_f;
      CC_FC:   o_taken = !w_f;
      CC_LO:   o_taken = !w_l && !w_z;
      CC_HS:   o_taken = w_l || w_z;
      CC_LT:   o_taken = !w_n && !w_z;
      CC_GE:   o_taken = w_n || w_z;
      CC_UC:   o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - one-entry writeback stage: RF write, PSR update, branch resolve
// Optional WB_FWD_EN exposes the held result for operand bypass.
module wb_stage
  import proc_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  logic          r_valid;
  logic [DW-1:0] r_result;
  logic [4:0]    r_cond;
  logic          r_flags_we;
  logic [RW-1:0] r_rd;
  logic          r_rd_we;
  logic          r_branch;
  logic [3:0]    r_bcond;
  logic [DW-1:0] r_target;
  psr_t          r_psr;

  logic w_commit;
  logic w_ready;
  logic w_capture;
  logic w_cc_true;

  assign w_commit  = r_valid && !bus.stall && !bus.flush;
  assign w_ready   = !r_valid || w_commit;
  assign w_capture = bus.in_valid && w_ready && !bus.flush;

  cond_eval u_cond_eval (
    .i_bcond (r_bcond),
    .i_psr   (r_psr),
    .o_taken (w_cc_true)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_cond     <= '0;
      r_flags_we <= 1'b0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
      r_branch   <= 1'b0;
      r_bcond    <= '0;
      r_target   <= '0;
      r_psr      <= '0;
    end else begin
      if (w_capture) begin
        r_valid    <= 1'b1;
        r_result   <= bus.in_result;
        r_cond     <= bus.in_cond;
        r_flags_we <= bus.in_flags_we;
        r_rd       <= bus.in_rd;
        r_rd_we    <= bus.in_rd_we;
        r_branch   <= bus.in_branch;
        r_bcond    <= bus.in_bcond;
        r_target   <= bus.in_target;
      end else if (w_commit || bus.flush) begin
        r_valid <= 1'b0;
      end
      // Branches never write flags, even when the decoder sets flags_we
      if (w_commit && r_flags_we && !r_branch) begin
        r_psr <= r_cond;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.rf_we     = w_commit && r_rd_we;
  assign bus.rf_waddr  = r_rd;
  assign bus.rf_wdata  = r_result;
  assign bus.psr       = r_psr;
  assign bus.br_taken  = w_commit && r_branch && w_cc_true;
  assign bus.br_target = r_target;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = r_valid && r_rd_we;
  assign bus.fwd_rd    = r_rd;
  assign bus.fwd_data  = r_result;
`endif

endmodule
